// File: rtl/oam_dma_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : oam_dma_arbiter
// Brief    : OAM DMA engine (160-byte copy to FE00) and CPU/DMA memory-bus
//            arbiter with an internal 127-byte HRAM at FF80..FFFE.
// Revision : 1.0 - initial release
//==============================================================================
module oam_dma_arbiter #(
    parameter int                  ADDR_SIZE    = 16,
    parameter int                  DATA_SIZE    = 8,
    parameter logic [ADDR_SIZE-1:0] DMA_REG_ADDR = 16'hFF46,
    parameter int                  DMA_LEN      = 160
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           t_cycle,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [DATA_SIZE-1:0] cpu_wdata,
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    output logic [DATA_SIZE-1:0] cpu_rdata,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    output logic                 mem_rd,
    output logic                 mem_wr,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic                 dma_active,
    output logic [DATA_SIZE-1:0] dma_reg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [1:0]           c_t0         = 2'b00;
    localparam logic [1:0]           c_t1         = 2'b01;
    localparam logic [1:0]           c_t2         = 2'b10;
    localparam logic [1:0]           c_t3         = 2'b11;
    localparam logic [7:0]           c_last_idx   = 8'(DMA_LEN - 1);
    localparam logic [7:0]           c_oam_page   = 8'hFE;
    localparam logic [ADDR_SIZE-1:0] c_hram_first = 16'hFF80;
    localparam logic [ADDR_SIZE-1:0] c_hram_last  = 16'hFFFE;
    localparam logic [DATA_SIZE-1:0] c_open_bus   = 8'hFF;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_idx;
    logic [7:0]           w_idx_nxt;
    logic [DATA_SIZE-1:0] r_src;
    logic [DATA_SIZE-1:0] w_src_nxt;
    logic [DATA_SIZE-1:0] r_latch;
    logic [DATA_SIZE-1:0] w_latch_nxt;
    logic [DATA_SIZE-1:0] r_dma_reg;
    logic [DATA_SIZE-1:0] w_dma_reg_nxt;
    logic [DATA_SIZE-1:0] r_hram [0:126];

    logic       w_hram_hit;
    logic       w_dma_reg_hit;
    logic       w_local_hit;
    logic       w_m_end;
    logic       w_start_req;
    logic [6:0] w_hram_idx;

    // Address decode of the CPU request
    assign w_hram_hit    = (cpu_addr >= c_hram_first) && (cpu_addr <= c_hram_last);
    assign w_dma_reg_hit = (cpu_addr == DMA_REG_ADDR);
    assign w_local_hit   = w_hram_hit || w_dma_reg_hit;
    assign w_hram_idx    = cpu_addr[6:0];
    assign w_m_end       = (t_cycle == c_t3);
    assign w_start_req   = cpu_wr && w_dma_reg_hit && w_m_end;

    assign dma_active = (r_state != IDLE);
    assign dma_reg    = r_dma_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_src     <= '0;
            r_latch   <= '0;
            r_dma_reg <= 8'hFF;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_src     <= w_src_nxt;
            r_latch   <= w_latch_nxt;
            r_dma_reg <= w_dma_reg_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_src_nxt     = r_src;
        w_latch_nxt   = r_latch;
        w_dma_reg_nxt = r_dma_reg;

        case (r_state)
            IDLE: begin
                w_state_nxt = IDLE;
            end
            START: begin
                if (w_m_end) begin
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (t_cycle == c_t1) begin
                    w_latch_nxt = mem_rdata;
                end
                if (w_m_end) begin
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // A register write wins over slot progress, which makes mid-transfer restarts seamless
        if (w_start_req) begin
            w_state_nxt   = START;
            w_idx_nxt     = '0;
            w_src_nxt     = cpu_wdata;
            w_dma_reg_nxt = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_wr && w_hram_hit) begin
            r_hram[w_hram_idx] <= cpu_wdata;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;

        if (r_state == ACTIVE) begin
            // The source address is held through T1 so the byte can be latched at the T1 edge
            case (t_cycle)
                c_t0: begin
                    mem_addr = {r_src, r_idx};
                    mem_rd   = 1'b1;
                end
                c_t1: begin
                    mem_addr = {r_src, r_idx};
                end
                c_t2: begin
                    mem_addr  = {c_oam_page, r_idx};
                    mem_wdata = r_latch;
                    mem_wr    = 1'b1;
                end
                default: begin
                    mem_addr  = {c_oam_page, r_idx};
                    mem_wdata = r_latch;
                end
            endcase
        end else if (!w_local_hit) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_rd    = cpu_rd && !cpu_wr;
            mem_wr    = cpu_wr;
        end

        if (rst) begin
            mem_addr  = '0;
            mem_wdata = '0;
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
        end
    end

    always_comb begin
        cpu_rdata = c_open_bus;
        if (w_hram_hit) begin
            cpu_rdata = r_hram[w_hram_idx];
        end else if (w_dma_reg_hit) begin
            cpu_rdata = r_dma_reg;
        end else if (r_state != ACTIVE) begin
            cpu_rdata = mem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_oam_dma_arbiter
// Brief    : Directed self-checking bench for oam_dma_arbiter with a 64 KiB
//            behavioural memory attached to the mem port.
// Revision : 1.0 - initial release
//==============================================================================
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  t_cycle = 2'b00;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_rdata;
    logic        dma_active;
    logic [7:0]  dma_reg;

    logic [7:0]  mem [0:65535];
    int          wr_count = 0;
    int          both_count = 0;
    int          glitch_count = 0;
    logic        watch_active = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          base;
    int          bad;
    logic [7:0]  rd_data;

    oam_dma_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .t_cycle    (t_cycle),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_rdata  (cpu_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata),
        .dma_active (dma_active),
        .dma_reg    (dma_reg)
    );

    always #5 clk = ~clk;

    // Asynchronous-read, clocked-write memory
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
        end
        if (mem_rd && mem_wr) begin
            both_count <= both_count + 1;
        end
    end

    always @(negedge clk) begin
        if (watch_active && !dma_active) begin
            glitch_count <= glitch_count + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: wait for the edge, then advance the T-state away from it
    task automatic tick();
        @(posedge clk);
        #1;
        t_cycle = t_cycle + 2'd1;
    endtask

    task automatic m_idle(input int n);
        repeat (4 * n) tick();
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wr    = 1'b1;
        repeat (4) tick();
        cpu_wr    = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        tick();
        tick();
        #1;
        d = cpu_rdata;
        tick();
        tick();
        cpu_rd = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (4) tick();
        #1;
        check("rst_dma_active", dma_active, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_dma_reg", dma_reg, 8'hFF);
        rst = 1'b0;

        // ---------------- fill source pages through the pass-through path ----------------
        for (int i = 0; i < 160; i++) cpu_write(16'(16'hC000 + i), 8'(i) ^ 8'h5A);
        cpu_write(16'hC100, 8'hAB);
        cpu_read(16'hC005, rd_data);
        check("idle_passthru_read", rd_data, 8'h5F);
        cpu_read(16'hFF46, rd_data);
        check("idle_ff46_read", rd_data, 8'hFF);

        // ---------------- basic transfer from page C0 ----------------
        cpu_write(16'hFF46, 8'hC0);
        #1;
        check("e0_dma_active", dma_active, 1'b1);
        check("e0_dma_reg", dma_reg, 8'hC0);
        check("start_no_dma_rd", mem_rd, 1'b0);

        // M-cycle 1 (START): CPU keeps the bus
        cpu_addr  = 16'hC200;
        cpu_wdata = 8'h11;
        cpu_wr    = 1'b1;
        #1;
        check("start_cpu_wr", mem_wr, 1'b1);
        check("start_cpu_addr", mem_addr, 16'hC200);
        repeat (4) tick();
        cpu_wr = 1'b0;
        base = wr_count;

        // M-cycle 2: byte 0 slot, CPU read of C000 is blocked
        cpu_addr = 16'hC000;
        cpu_rd   = 1'b1;
        #1;
        check("b0_t0_mem_rd", mem_rd, 1'b1);
        check("b0_t0_mem_addr", mem_addr, 16'hC000);
        check("b0_t0_mem_wr", mem_wr, 1'b0);
        check("active_cpu_read_ff", cpu_rdata, 8'hFF);
        tick();
        tick();
        #1;
        check("b0_t2_mem_wr", mem_wr, 1'b1);
        check("b0_t2_mem_rd", mem_rd, 1'b0);
        check("b0_t2_mem_addr", mem_addr, 16'hFE00);
        check("b0_t2_mem_wdata", mem_wdata, 8'h5A);
        tick();
        #1;
        check("b0_t3_no_strobe", {mem_rd, mem_wr}, 2'b00);
        tick();
        cpu_rd = 1'b0;

        // M-cycles 3..6: blocked write, HRAM write/read, FF46 read
        cpu_write(16'hC100, 8'h77);
        cpu_write(16'hFF90, 8'h3C);
        cpu_read(16'hFF90, rd_data);
        check("active_hram_read", rd_data, 8'h3C);
        cpu_read(16'hFF46, rd_data);
        check("active_ff46_read", rd_data, 8'hC0);

        m_idle(154);
        #1;
        check("m161_still_active", dma_active, 1'b1);
        m_idle(1);
        #1;
        check("m162_idle", dma_active, 1'b0);
        check("c0_wr_count", wr_count - base, 160);
        check("blocked_write_c100", mem[16'hC100], 8'hAB);
        check("start_write_c200", mem[16'hC200], 8'h11);
        bad = 0;
        for (int i = 0; i < 160; i++) if (mem[16'(16'hFE00 + i)] !== (8'(i) ^ 8'h5A)) bad++;
        check("oam_copy_c0", bad, 0);
        cpu_read(16'hFF90, rd_data);
        check("idle_hram_read", rd_data, 8'h3C);

        // ---------------- restart at byte 80 with page D0 ----------------
        for (int i = 0; i < 160; i++) cpu_write(16'(16'hD000 + i), 8'(i) ^ 8'hA5);
        for (int i = 0; i < 160; i++) cpu_write(16'(16'hFE00 + i), 8'h00);
        cpu_write(16'hFF46, 8'hC0);
        watch_active = 1'b1;
        m_idle(81);
        cpu_write(16'hFF46, 8'hD0);
        bad = 0;
        for (int i = 0; i < 81; i++) if (mem[16'(16'hFE00 + i)] !== (8'(i) ^ 8'h5A)) bad++;
        check("restart_partial_c0", bad, 0);
        check("restart_fe51_untouched", mem[16'hFE51], 8'h00);
        check("restart_dma_reg", dma_reg, 8'hD0);
        base = wr_count;
        m_idle(160);
        #1;
        check("restart_m161_active", dma_active, 1'b1);
        watch_active = 1'b0;
        m_idle(1);
        #1;
        check("restart_m162_idle", dma_active, 1'b0);
        check("restart_wr_count", wr_count - base, 160);
        check("restart_no_glitch", glitch_count, 0);
        bad = 0;
        for (int i = 0; i < 160; i++) if (mem[16'(16'hFE00 + i)] !== (8'(i) ^ 8'hA5)) bad++;
        check("oam_copy_d0", bad, 0);

        // ---------------- reset abort at byte 40 ----------------
        for (int i = 0; i < 160; i++) cpu_write(16'(16'hFE00 + i), 8'hEE);
        cpu_write(16'hFF46, 8'hC0);
        m_idle(41);
        rst = 1'b1;
        #1;
        check("abort_rst_mem_rd", mem_rd, 1'b0);
        check("abort_rst_mem_addr", mem_addr, 16'h0000);
        tick();
        rst = 1'b0;
        base = wr_count;
        #1;
        check("abort_dma_active", dma_active, 1'b0);
        check("abort_dma_reg", dma_reg, 8'hFF);
        repeat (3) tick();
        m_idle(170);
        check("abort_no_writes", wr_count - base, 0);
        bad = 0;
        for (int i = 0; i < 160; i++) begin
            if (i < 40) begin
                if (mem[16'(16'hFE00 + i)] !== (8'(i) ^ 8'h5A)) bad++;
            end else begin
                if (mem[16'(16'hFE00 + i)] !== 8'hEE) bad++;
            end
        end
        check("abort_oam_partial", bad, 0);
        cpu_read(16'hFF90, rd_data);
        check("hram_survives_rst", rd_data, 8'h3C);

        // ---------------- self-copy from page FE ----------------
        for (int i = 0; i < 160; i++) cpu_write(16'(16'hFE00 + i), 8'(i) ^ 8'h3C);
        cpu_write(16'hFF46, 8'hFE);
        m_idle(1);
        base = wr_count;
        cpu_read(16'hFFFF, rd_data);
        check("active_ffff_read", rd_data, 8'hFF);
        m_idle(158);
        #1;
        check("self_m161_active", dma_active, 1'b1);
        m_idle(1);
        #1;
        check("self_m162_idle", dma_active, 1'b0);
        check("self_wr_count", wr_count - base, 160);
        bad = 0;
        for (int i = 0; i < 160; i++) if (mem[16'(16'hFE00 + i)] !== (8'(i) ^ 8'h3C)) bad++;
        check("oam_self_copy", bad, 0);
        check("never_rd_and_wr", both_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
